// File: rtl/program_loader_pkg.sv
// Shared types and frame constants for the boot-time program loader.
// The CHECK state exists only when PROGRAM_LOADER_CHECKSUM_EN is defined.
package program_loader_pkg;

  localparam int LEN_FIELD_BYTES = 2;
  localparam int BYTES_PER_WORD  = 4;
  localparam int LEN_BITS        = 8 * LEN_FIELD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Handshake: a byte moves on a rising edge where byte_valid and byte_ready are both 1;
// byte_data must be stable while byte_valid is high, and byte_ready never waits on byte_valid.
interface program_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_wren;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_wren, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_wren, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Big-endian 8-to-32 packer: the first byte of a group lands in bits 31:24.
// word_valid pulses for one cycle after the fourth byte; word holds until the next completion.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        completing,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  assign completing = byte_en && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (byte_en) begin
        shift_q <= {shift_q[15:0], byte_in};
        cnt_q   <= cnt_q + 2'd1;
        if (cnt_q == LAST_BYTE) begin
          word       <= {shift_q, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte frame, writes words to imem from address 0,
// and releases the CPU when the image is complete. PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  program_loader_if.slave  bus,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error,
  output state_t           fsm_state
);

  localparam logic [LEN_BITS:0] CAPACITY = (LEN_BITS + 1)'(1) << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic                  xfer;
  logic                  start_ok;
  logic                  in_data;
  logic                  last_word;
  logic [7:0]            len_hi_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   n_field;
  logic [ADDR_WIDTH:0]   word_idx_q;
  logic [31:0]           waddr_q;
  logic                  asm_completing;
  logic                  asm_valid;
  logic [31:0]           asm_word;
  logic                  ready_c, busy_c;
  logic                  hold_d, done_d, error_d;

  assign xfer      = bus.byte_valid && bus.byte_ready;
  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
  assign in_data   = xfer && (state_q == ST_DATA);
  assign n_field   = {len_hi_q, bus.byte_data};
  assign last_word = ((LEN_BITS + 1)'(word_idx_q) + (LEN_BITS + 1)'(1)) == {1'b0, len_q};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_q <= '0;
    end else if (start_ok) begin
      chk_q <= '0;
    end else if (in_data) begin
      chk_q <= chk_q ^ bus.byte_data;
    end
  end
`endif

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .byte_en    (in_data),
    .byte_in    (bus.byte_data),
    .completing (asm_completing),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (xfer) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (xfer) begin
          if (n_field == '0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
`endif
          end else if ({1'b0, n_field} > CAPACITY) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (asm_completing && last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) state_d = (bus.byte_data == chk_q) ? ST_DONE : ST_ERROR;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (start) state_d = ST_LEN_HI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags lag the state by one cycle so the CPU is released strictly after the final write.
  always_comb begin
    ready_c = 1'b0;
    busy_c  = 1'b0;
    hold_d  = 1'b1;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_LEN_HI, ST_LEN_LO, ST_DATA: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        ready_c = 1'b1;
        busy_c  = 1'b1;
      end
`endif
      ST_DONE: begin
        hold_d = start_ok;
        done_d = !start_ok;
      end
      ST_ERROR: begin
        error_d = !start_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      cpu_hold <= hold_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len_hi_q   <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      waddr_q    <= '0;
    end else begin
      if (start_ok) begin
        word_idx_q <= '0;
      end
      if (xfer && state_q == ST_LEN_HI) len_hi_q <= bus.byte_data;
      if (xfer && state_q == ST_LEN_LO) len_q    <= n_field;
      // Address is latched with the completing byte so it lines up with the packer's word_valid.
      if (asm_completing) begin
        waddr_q    <= 32'(word_idx_q[ADDR_WIDTH-1:0]) << 2;
        word_idx_q <= word_idx_q + 1'b1;
      end
    end
  end

  assign bus.byte_ready = ready_c;
  assign bus.imem_wren  = asm_valid;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = asm_word;
  assign busy           = busy_c;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame driver tasks, imem write scoreboard, final report.
// Works with PROGRAM_LOADER_CHECKSUM_EN defined or not.
module tb_program_loader;
  import program_loader_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  logic   start = 1'b0;
  logic   cpu_hold, busy, done, error;
  state_t fsm_state;

  program_loader_if bus ();

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          wren_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic [31:0] frame_words[256];

  // Scoreboard: every imem write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (rst && bus.imem_wren === 1'b1) begin
      wren_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL imem_write_unexpected: addr=%h data=%h, no write expected", bus.imem_waddr, bus.imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.imem_waddr, bus.imem_wdata} !== mon_exp)
        begin
          errors++;
          $display("FAIL imem_write: got addr=%h data=%h, expected addr=%h data=%h",
                   bus.imem_waddr, bus.imem_wdata, mon_exp[63:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: byte_ready=%b, required 1 within 20 cycles", bus.byte_ready);
    end
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad_chk);
    logic [7:0]  chk;
    logic [31:0] wd;
    logic [15:0] len;
    chk = 8'h00;
    len = 16'(n);
    pulse_start();
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int w = 0; w < n; w++) begin
      wd = frame_words[w];
      exp_q.push_back({32'(w * 4), wd});
      for (int b = 0; b < 4; b++) begin
        chk = chk ^ wd[31 - 8 * b -: 8];
        send_byte(wd[31 - 8 * b -: 8]);
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(bad_chk ? ~chk : chk);
`else
    if (bad_chk) chk = ~chk;
`endif
  endtask

  task automatic expect_done(input string name);
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: done=%b cpu_hold=%b error=%b busy=%b, required 1 0 0 0",
               name, done, cpu_hold, error, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_writes: %0d writes outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    repeat (2) tick();
    checks++;
    if (bus.byte_ready !== 1'b0 || bus.imem_wren !== 1'b0 || bus.imem_waddr !== 32'h0 ||
        bus.imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: ready=%b wren=%b waddr=%h wdata=%h, required 0 0 0 0",
               bus.byte_ready, bus.imem_wren, bus.imem_waddr, bus.imem_wdata);
    end
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_status: hold=%b busy=%b done=%b error=%b state=%0d, required 1 0 0 0 IDLE",
               cpu_hold, busy, done, error, fsm_state);
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.byte_ready !== 1'b0 || fsm_state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_ignores_bytes: ready=%b state=%0d, required 0 IDLE", bus.byte_ready, fsm_state);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    frame_words[0] = 32'h2008_0005;
    frame_words[1] = 32'h0109_4020;
    send_frame(2, 1'b0);
    checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL basic_release_early: done=%b cpu_hold=%b, required 0 1", done, cpu_hold);
    end
    tick();
    expect_done("basic");
  endtask

  task automatic test_bad_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    frame_words[0] = 32'h2008_0005;
    frame_words[1] = 32'h0109_4020;
    send_frame(2, 1'b1);
    tick();
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL bad_checksum: error=%b cpu_hold=%b done=%b, required 1 1 0", error, cpu_hold, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bad_checksum_writes: %0d outstanding, required 0", exp_q.size());
    end
`endif
  endtask

  task automatic test_oversize();
    int wc;
    wc = wren_cnt;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    checks++;
    if (fsm_state !== ST_ERROR) begin
      errors++;
      $display("FAIL oversize_state: state=%0d, required ERROR", fsm_state);
    end
    tick();
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bus.byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_flags: error=%b hold=%b done=%b busy=%b ready=%b, required 1 1 0 0 0",
               error, cpu_hold, done, busy, bus.byte_ready);
    end
    repeat (3) tick();
    checks++;
    if (wren_cnt != wc) begin
      errors++;
      $display("FAIL oversize_writes: %0d writes, required 0", wren_cnt - wc);
    end
  endtask

  task automatic test_throttle();
    logic [7:0]  bytes[8];
    logic [31:0] wd;
    int          nb;
    wd = $urandom();
    bytes[0] = 8'h00;
    bytes[1] = 8'h01;
    for (int b = 0; b < 4; b++) bytes[2 + b] = wd[31 - 8 * b -: 8];
    nb = 6;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    bytes[6] = wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0];
    nb = 7;
`endif
    exp_q.push_back({32'h0, wd});
    pulse_start();
    for (int i = 0; i < nb; i++) begin
      bus.byte_valid = 1'b0;
      checks++;
      if (bus.byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL throttle_ready_idle: byte %0d ready=%b, required 1", i, bus.byte_ready);
      end
      tick();
      bus.byte_valid = 1'b1;
      bus.byte_data  = bytes[i];
      checks++;
      if (bus.byte_ready !== 1'b1) begin
        errors++;
        $display("FAIL throttle_ready_valid: byte %0d ready=%b, required 1", i, bus.byte_ready);
      end
      tick();
    end
    bus.byte_valid = 1'b0;
    tick();
    expect_done("throttle");
  endtask

  task automatic test_reset_midload();
    int wc;
    wc = wren_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (fsm_state !== ST_IDLE || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL midload_reset: state=%0d busy=%b hold=%b, required IDLE 0 1", fsm_state, busy, cpu_hold);
    end
    frame_words[0] = 32'hDEAD_BEEF;
    send_frame(1, 1'b0);
    tick();
    expect_done("midload_reload");
    checks++;
    if (wren_cnt != wc + 1) begin
      errors++;
      $display("FAIL midload_write_count: %0d writes, required 1", wren_cnt - wc);
    end
  endtask

  task automatic test_zero_len();
    int wc;
    wc = wren_cnt;
    send_frame(0, 1'b0);
    tick();
    expect_done("zero_len");
    checks++;
    if (wren_cnt != wc) begin
      errors++;
      $display("FAIL zero_len_writes: %0d writes, required 0", wren_cnt - wc);
    end
  endtask

  task automatic test_zero_word();
    frame_words[0] = 32'h0000_0000;
    send_frame(1, 1'b0);
    tick();
    expect_done("zero_word");
  endtask

  task automatic test_start_ignored();
    logic [31:0] wd;
    wd = $urandom();
    exp_q.push_back({32'h0, wd});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(wd[31:24]);
    pulse_start();
    checks++;
    if (fsm_state !== ST_DATA) begin
      errors++;
      $display("FAIL start_while_busy: state=%0d, required DATA", fsm_state);
    end
    send_byte(wd[23:16]);
    send_byte(wd[15:8]);
    send_byte(wd[7:0]);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(wd[31:24] ^ wd[23:16] ^ wd[15:8] ^ wd[7:0]);
`endif
    tick();
    expect_done("start_ignored");
  endtask

  task automatic test_full_capacity();
    for (int w = 0; w < 256; w++) frame_words[w] = $urandom();
    send_frame(256, 1'b0);
    tick();
    expect_done("full_capacity");
    checks++;
    if (bus.imem_waddr !== 32'h0000_03FC) begin
      errors++;
      $display("FAIL full_capacity_last_addr: waddr=%h, required 000003fc", bus.imem_waddr);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 3; f++) begin
      n = $urandom_range(1, 5);
      for (int w = 0; w < n; w++) frame_words[w] = $urandom();
      send_frame(n, 1'b0);
      tick();
      expect_done("back_to_back");
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_basic();
    test_bad_checksum();
    test_oversize();
    test_throttle();
    test_reset_midload();
    test_zero_len();
    test_zero_word();
    test_start_ignored();
    test_full_capacity();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
